hazard_ctrl: RTL

//  Pipeline sequencing controller for the 5-stage RV32 datapath (IF/ID/EX/MEM/WB).

---
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// RAW hazard stall / redirect flush sequencer for the 5-stage RV32 pipe; outputs are same-cycle combinational.
// Reg_Stall holds PC + IF/ID for exactly the producer's distance; redirect overrides and flushes.
// Optional HAZARD_PERF_EN adds saturating stall-cycle and flush counters.
module hazard_ctrl #(
  parameter int RF_ADDRESS  = 5,
  parameter int STALL_CNT_W = 2
`ifdef HAZARD_PERF_EN
  ,
  parameter int PERF_W      = 32
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RF_ADDRESS-1:0] id_rs1,
  input  logic [RF_ADDRESS-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [RF_ADDRESS-1:0] ex_rd,
  input  logic                  ex_regwrite,
  input  logic [RF_ADDRESS-1:0] mem_rd,
  input  logic                  mem_regwrite,
  input  logic [RF_ADDRESS-1:0] wb_rd,
  input  logic                  wb_regwrite,
  input  logic                  redirect,
  output logic                  Reg_Stall,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic                  ex_mem_flush,
  output logic                  busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]     perf_stall_cycles,
  output logic [PERF_W-1:0]     perf_flushes
`endif
);

  typedef enum logic {RUN, STALL} state_t;

  state_t                 state;
  logic [STALL_CNT_W-1:0] cnt;
  logic [STALL_CNT_W-1:0] depth;
  logic [STALL_CNT_W-1:0] depth_m1;
  logic [STALL_CNT_W-1:0] cnt_dec;
  logic [STALL_CNT_W-1:0] cnt_nxt;
  logic                   match_ex;
  logic                   match_mem;
  logic                   match_wb;
  logic                   hazard;

  // x0 is never a real producer, so it is excluded from every match.
  always_comb begin
    match_ex  = ex_regwrite  && (ex_rd  != '0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd))  || (id_use_rs2 && (id_rs2 == ex_rd)));
    match_mem = mem_regwrite && (mem_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == mem_rd)) || (id_use_rs2 && (id_rs2 == mem_rd)));
    match_wb  = wb_regwrite  && (wb_rd  != '0) &&
                ((id_use_rs1 && (id_rs1 == wb_rd))  || (id_use_rs2 && (id_rs2 == wb_rd)));
  end

  // Nearest writer decides how many cycles the consumer must wait.
  always_comb begin
    depth = '0;
    if (match_ex)       depth = STALL_CNT_W'(3);
    else if (match_mem) depth = STALL_CNT_W'(2);
    else if (match_wb)  depth = STALL_CNT_W'(1);
  end

  always_comb begin
    hazard   = (depth != '0) && !redirect;
    depth_m1 = (depth == '0) ? '0 : depth - STALL_CNT_W'(1);
    cnt_dec  = (cnt == '0)   ? '0 : cnt - STALL_CNT_W'(1);
    cnt_nxt  = cnt_dec;
    if (hazard && (depth_m1 > cnt_dec)) cnt_nxt = depth_m1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else if (redirect) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (hazard) begin
            cnt   <= depth_m1;
            state <= (depth > STALL_CNT_W'(1)) ? STALL : RUN;
          end
        end
        STALL: begin
          cnt   <= cnt_nxt;
          state <= (cnt_nxt == '0) ? RUN : STALL;
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Outputs are forced low while reset is held, independent of the inputs.
  always_comb begin
    busy         = !reset && (state == STALL);
    Reg_Stall    = !reset && (hazard || busy) && !redirect;
    id_ex_bubble = !reset && (hazard || busy || redirect);
    if_id_flush  = !reset && redirect;
    ex_mem_flush = !reset && redirect;
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
    end else begin
      if (Reg_Stall && !(&perf_stall_cycles)) perf_stall_cycles <= perf_stall_cycles + PERF_W'(1);
      if (redirect && !(&perf_flushes))       perf_flushes      <= perf_flushes + PERF_W'(1);
    end
  end
`endif

endmodule
